mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all request channels.
REQ-002 Parameter DATA_W, default 32, data width; wmask width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req_valid  input  1  fetch read request.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_resp_valid  output  1  fetch read data valid.
REQ-009 if_rdata  output  DATA_W  fetch read data.
REQ-010 ls_req_valid  input  1  load/store request.
REQ-011 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-012 ls_addr  input  ADDR_W  load/store address.
REQ-013 ls_wen  input  1  1 = store, 0 = load.
REQ-014 ls_wdata  input  DATA_W  store data.
REQ-015 ls_wmask  input  DATA_W/8  store byte mask.
REQ-016 ls_resp_valid  output  1  load data / store completion valid.
REQ-017 ls_rdata  output  DATA_W  load data.
REQ-018 mem_req_valid  output  1  request to shared memory port.
REQ-019 mem_req_ready  input  1  memory accepts request.
REQ-020 mem_addr / mem_wen / mem_wdata / mem_wmask  output  ADDR_W / 1 / DATA_W / DATA_W/8  registered request payload.
REQ-021 mem_resp_valid  input  1  memory response valid (any latency >= 1 cycle after acceptance).
REQ-022 mem_rdata  input  DATA_W  memory response data.

Function
REQ-023 FSM states IDLE, REQ, RESP; exactly one transaction outstanding.
REQ-024 IDLE: if any req_valid, assert ready of winner only, latch payload and owner (IF/LS), go REQ next cycle; IF payload latched with wen=0, wmask=0.
REQ-025 Default arbitration: LS wins when both valid; never both readys high in one cycle.
REQ-026 REQ: mem_req_valid=1 with latched payload held stable until mem_req_ready; on handshake go RESP.
REQ-027 RESP: on mem_resp_valid, owner's resp_valid=1 combinationally same cycle, rdata = mem_rdata; go IDLE next cycle.
REQ-028 Non-owner resp_valid stays 0; xx_rdata of non-owner is don't-care.
REQ-029 mem_resp_valid in IDLE or REQ is ignored.
REQ-030 Minimum latency: accept at cycle N, mem handshake N+1, response earliest N+2; next accept earliest N+3.
REQ-031 Store receives ls_resp_valid pulse on mem_resp_valid like a load.
REQ-032 Requesters' valid dropping after ready has no effect on in-flight transaction.

Reset
REQ-033 rst=1 at clock edge: state=IDLE, owner=IF, all readys/valids 0, mem payload 0; in-flight transaction abandoned, late mem_resp_valid ignored.
REQ-034 Outputs settle to reset values in first cycle after rst asserted; accept allowed first cycle after rst deasserts.

Configuration
REQ-035 Macro ARB_RR_EN defined: round-robin on simultaneous requests, grant the requester not served last; last-served register resets to LS (IF wins first tie).
REQ-036 ARB_RR_EN undefined: fixed LS priority per REQ-025, no last-served register.

Structure
REQ-037 State enum (IDLE/REQ/RESP) and owner enum (IF/LS) in shared package arb_pkg.
REQ-038 Grant selection in sub-module arb_pick (two valids + last-served in, one-hot grant out); rest in mem_arbiter.

Verification
REQ-039 IF only, addr 0x80000000, mem ready immediately, resp 2 cycles later rdata 0x00000413 -> if_resp_valid one cycle, if_rdata 0x00000413, ls_resp_valid 0.
REQ-040 Both valid same cycle, no ARB_RR_EN -> ls_req_ready first; IF accepted cycle after LS response.
REQ-041 ARB_RR_EN, both valid continuously for 4 transactions -> grant order IF, LS, IF, LS.
REQ-042 LS store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready held 0 for 3 cycles -> mem payload stable 3 cycles, mem_wen=1, ls_resp_valid on mem_resp_valid.
REQ-043 rst asserted in RESP, mem_resp_valid arrives next cycle -> no resp_valid pulse, state IDLE.
REQ-044 mem_resp_valid pulsed while IDLE with no request -> no output change.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the fetch/load-store memory arbiter
// Contents: FSM state enum, transaction owner enum, one-hot grant bit indices.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int GNT_IF = 0;
    localparam int GNT_LS = 1;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - grant selection between fetch and load/store requesters
// Ports: if_valid, ls_valid (request valids), last (owner served last),
//        grant[1:0] one-hot grant, bit GNT_IF / GNT_LS.
// Macro ARB_RR_EN: round-robin on ties; undefined gives fixed LS priority.
module arb_pick
    import arb_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
    input  owner_t     last,
    output logic [1:0] grant
);

`ifdef ARB_RR_EN
    always_comb begin
        grant = 2'b00;
        if (if_valid && ls_valid) begin
            // Tie: hand the port to whoever did not get it last time.
            if (last == OWN_LS) begin
                grant[GNT_IF] = 1'b1;
            end else begin
                grant[GNT_LS] = 1'b1;
            end
        end else if (ls_valid) begin
            grant[GNT_LS] = 1'b1;
        end else if (if_valid) begin
            grant[GNT_IF] = 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant = 2'b00;
        if (ls_valid) begin
            grant[GNT_LS] = 1'b1;
        end else if (if_valid) begin
            grant[GNT_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and load/store onto one memory port
// Ports: clk, rst (sync active-high); fetch if_req_*/if_addr/if_resp_valid/if_rdata;
//        load/store ls_req_*/ls_addr/ls_wen/ls_wdata/ls_wmask/ls_resp_valid/ls_rdata;
//        memory mem_req_valid/ready, mem_addr/wen/wdata/wmask, mem_resp_valid/rdata.
// Macro ARB_RR_EN: round-robin tie-breaking with a last-served register.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    state_t     state;
    state_t     state_nx;
    owner_t     owner;
    owner_t     last_served;
    logic [1:0] grant;
    logic       accept;

    arb_pick u_pick (
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .last     (last_served),
        .grant    (grant)
    );

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= OWN_LS;
        end else if (accept) begin
            last_served <= grant[GNT_LS] ? OWN_LS : OWN_IF;
        end
    end
`else
    assign last_served = OWN_LS;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                if (grant[GNT_LS]) begin
                    owner     <= OWN_LS;
                    mem_addr  <= ls_addr;
                    mem_wen   <= ls_wen;
                    mem_wdata <= ls_wdata;
                    mem_wmask <= ls_wmask;
                end else begin
                    owner     <= OWN_IF;
                    mem_addr  <= if_addr;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    mem_wmask <= {MASK_W{1'b0}};
                end
            end
        end
    end

    // Readys and response valids are held low while rst is high so that
    // nothing is handed over in a cycle whose edge is about to be discarded.
    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst && (grant != 2'b00)) begin
                    accept       = 1'b1;
                    if_req_ready = grant[GNT_IF];
                    ls_req_ready = grant[GNT_LS];
                    state_nx     = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_resp_valid) begin
                    if_resp_valid = !rst && (owner == OWN_IF);
                    ls_resp_valid = !rst && (owner == OWN_LS);
                    state_nx      = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Both requesters see the memory data; only the owner's valid qualifies it.
    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

endmodule
